// File: rtl/neuron_trainer_if.sv
// Feeder-to-trainer bus: sample handshake inputs and the trained-weight outputs.
interface neuron_trainer_if;
  logic [31:0]        nInput;
  logic signed [6:0]  x1Input;
  logic signed [6:0]  x2Input;
  logic [1:0]         tInput;
  logic               dataReady;
  logic               requestFlag;
  logic               done;
  logic signed [13:0] w1;
  logic signed [13:0] w2;
  logic signed [13:0] b;

  modport master (
    output nInput, x1Input, x2Input, tInput, dataReady,
    input  requestFlag, done, w1, w2, b
  );

  modport slave (
    input  nInput, x1Input, x2Input, tInput, dataReady,
    output requestFlag, done, w1, w2, b
  );
endinterface

// File: rtl/neuron_trainer.sv
// Two-input perceptron trainer with bipolar step activation and saturating
// weight updates; pulls one sample per REQ/CALC/UPD pass until an epoch is clean.
module neuron_trainer #(
  parameter int MAX_EPOCHS = 255,
  parameter int WSAT_MAX   = 8191,
  parameter int WSAT_MIN   = -8192
) (
  input  logic            clk,
  input  logic            rst,
  neuron_trainer_if.slave bus
);
  typedef enum logic [2:0] {START, REQ, CALC, UPD, DONE} state_t;

  typedef struct packed {
    logic signed [6:0] x1;
    logic signed [6:0] x2;
    logic              t_pos;
  } sample_t;

  localparam logic signed [14:0] SAT_HI    = 15'(WSAT_MAX);
  localparam logic signed [14:0] SAT_LO    = 15'(WSAT_MIN);
  localparam logic [31:0]        EPOCH_LIM = 32'(MAX_EPOCHS);

  state_t             state, state_nx;
  sample_t            smp;
  logic [31:0]        n_lat, cnt, epoch;
  logic               changed, err, req_q, done_q;
  logic signed [13:0] w1_q, w2_q, b_q;
  logic signed [20:0] p1, p2;
  logic signed [22:0] y_in;
  logic               y_neg, epoch_end, epoch_more;

  // One update step: w +/- x, clamped instead of wrapping.
  function automatic logic signed [13:0] sat_add(input logic signed [13:0] w,
                                                 input logic signed [6:0]  x,
                                                 input logic               pos);
    logic signed [14:0] s;
    s = pos ? (15'(w) + 15'(x)) : (15'(w) - 15'(x));
    if (s > SAT_HI) return 14'(SAT_HI);
    if (s < SAT_LO) return 14'(SAT_LO);
    return 14'(s);
  endfunction

  assign p1    = 21'(w1_q) * 21'($signed(smp.x1));
  assign p2    = 21'(w2_q) * 21'($signed(smp.x2));
  assign y_in  = 23'(p1) + 23'(p2) + 23'(b_q);
  assign y_neg = (y_in < 23'sd0);

  // The sample in UPD counts toward this epoch's change flag.
  assign epoch_end  = ((cnt + 32'd1) >= n_lat);
  assign epoch_more = (changed | err) && ((epoch + 32'd1) < EPOCH_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= START;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      START:   state_nx = (bus.nInput == 32'd0) ? DONE : REQ;
      REQ:     if (bus.dataReady) state_nx = CALC;
      CALC:    state_nx = UPD;
      UPD:     state_nx = (epoch_end && !epoch_more) ? DONE : REQ;
      DONE:    state_nx = DONE;
      default: state_nx = START;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp     <= '0;
      n_lat   <= '0;
      cnt     <= '0;
      epoch   <= '0;
      changed <= 1'b0;
      err     <= 1'b0;
      w1_q    <= '0;
      w2_q    <= '0;
      b_q     <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      req_q  <= (state_nx == REQ);
      done_q <= (state_nx == DONE);
      case (state)
        START: begin
          n_lat   <= bus.nInput;
          cnt     <= '0;
          epoch   <= '0;
          changed <= 1'b0;
        end
        REQ: if (bus.dataReady)
          smp <= '{x1: bus.x1Input, x2: bus.x2Input, t_pos: (bus.tInput == 2'b01)};
        CALC: err <= (!y_neg) != smp.t_pos;
        UPD: begin
          if (err) begin
            w1_q    <= sat_add(w1_q, smp.x1, smp.t_pos);
            w2_q    <= sat_add(w2_q, smp.x2, smp.t_pos);
            b_q     <= sat_add(b_q, 7'sd1, smp.t_pos);
            changed <= 1'b1;
          end
          if (epoch_end && epoch_more) begin
            epoch   <= epoch + 32'd1;
            changed <= 1'b0;
            cnt     <= '0;
            n_lat   <= bus.nInput;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.requestFlag = req_q;
  assign bus.done        = done_q;
  assign bus.w1          = w1_q;
  assign bus.w2          = w2_q;
  assign bus.b           = b_q;
endmodule

// File: tb/tb_neuron_trainer.sv
// Bench for neuron_trainer: a default-parameter instance plus a small-bound,
// 4-epoch instance; a reference perceptron model feeds a weight scoreboard.
module tb_neuron_trainer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst0, rst1;
  int                sel;
  logic [31:0]       nin;
  logic signed [6:0] x1, x2;
  logic [1:0]        t;
  logic              dr;

  neuron_trainer_if bus0 ();
  neuron_trainer_if bus1 ();

  assign bus0.nInput    = nin;
  assign bus0.x1Input   = x1;
  assign bus0.x2Input   = x2;
  assign bus0.tInput    = t;
  assign bus0.dataReady = dr && (sel == 0);
  assign bus1.nInput    = nin;
  assign bus1.x1Input   = x1;
  assign bus1.x2Input   = x2;
  assign bus1.tInput    = t;
  assign bus1.dataReady = dr && (sel == 1);

  neuron_trainer dut0 (.clk(clk), .rst(rst0), .bus(bus0));
  neuron_trainer #(.MAX_EPOCHS(4), .WSAT_MAX(40), .WSAT_MIN(-40))
    dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  logic               req_o, done_o;
  logic signed [13:0] w1_o, w2_o, b_o;
  assign req_o  = (sel == 1) ? bus1.requestFlag : bus0.requestFlag;
  assign done_o = (sel == 1) ? bus1.done        : bus0.done;
  assign w1_o   = (sel == 1) ? bus1.w1          : bus0.w1;
  assign w2_o   = (sel == 1) ? bus1.w2          : bus0.w2;
  assign b_o    = (sel == 1) ? bus1.b           : bus0.b;

  typedef struct { int w1; int w2; int b; } wexp_t;
  wexp_t sbq[$];

  int       vectors = 0;
  int       miscompares = 0;
  int       sx1[4], sx2[4];
  logic [1:0] st[4];

  function automatic int clampw(input int v);
    int hi, lo;
    hi = (sel == 1) ? 40 : 8191;
    lo = (sel == 1) ? -40 : -8192;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    dr = 1'b0;
    if (sel == 1) rst1 = 1'b0; else rst0 = 1'b0;
    repeat (2) @(negedge clk);
    if (sel == 1) rst1 = 1'b1; else rst0 = 1'b1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_o || done_o) begin ok = 1'b1; return; end
    end
  endtask

  task automatic set_sample(input int i, input int a, input int c, input logic [1:0] tt);
    sx1[i] = a; sx2[i] = c; st[i] = tt;
  endtask

  // Serves samples in order until the model says training ends; hold keeps
  // dataReady high through CALC and UPD to show it is ignored there.
  task automatic train(input int n, input int maxep, input bit hold, output int served);
    int mw1, mw2, mb, ep, cnt, idx, yin;
    bit chg, mdone, ok, tp, er;
    wexp_t e;
    mw1 = 0; mw2 = 0; mb = 0; ep = 0; cnt = 0; idx = 0;
    chg = 0; mdone = 0; served = 0;
    while (!mdone && served < 2000) begin
      wait_ready(ok);
      if (!ok) begin
        vectors++; miscompares++;
        $display("FAIL train_timeout: no request after %0d samples", served);
        return;
      end
      if (done_o) break;
      x1 = 7'(sx1[idx]); x2 = 7'(sx2[idx]); t = st[idx]; dr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (hold) begin @(negedge clk); @(negedge clk); end
      dr = 1'b0;
      served++;
      yin = mb + mw1 * sx1[idx] + mw2 * sx2[idx];
      tp  = (st[idx] == 2'b01);
      er  = ((yin >= 0) != tp);
      if (er) begin
        mw1 = clampw(mw1 + (tp ? sx1[idx] : -sx1[idx]));
        mw2 = clampw(mw2 + (tp ? sx2[idx] : -sx2[idx]));
        mb  = clampw(mb + (tp ? 1 : -1));
        chg = 1'b1;
      end
      e.w1 = mw1; e.w2 = mw2; e.b = mb;
      sbq.push_back(e);
      cnt++;
      idx = (idx + 1) % n;
      if (cnt == n) begin
        if (!chg || ep + 1 >= maxep) mdone = 1'b1;
        else begin ep++; chg = 1'b0; cnt = 0; end
      end
      wait_ready(ok);
      if (!ok) begin
        vectors++; miscompares++;
        $display("FAIL update_timeout: sample %0d never completed", served);
        return;
      end
      e = sbq.pop_front();
      vectors++;
      if (w1_o !== 14'(e.w1) || w2_o !== 14'(e.w2) || b_o !== 14'(e.b)) begin
        miscompares++;
        $display("FAIL sb_weights sample %0d: got w1=%0d w2=%0d b=%0d, expected w1=%0d w2=%0d b=%0d",
                 served, w1_o, w2_o, b_o, e.w1, e.w2, e.b);
      end
    end
    vectors++;
    if (done_o !== 1'b1 || !mdone) begin
      miscompares++;
      $display("FAIL train_done: got done=%b after %0d samples, model finished=%0d", done_o, served, mdone);
    end
  endtask

  task automatic check_final(input string name, input int served, input int exp_served,
                             input int e1, input int e2, input int eb);
    vectors++;
    if (served != exp_served || w1_o !== 14'(e1) || w2_o !== 14'(e2) || b_o !== 14'(eb)) begin
      miscompares++;
      $display("FAIL %s: got served=%0d w1=%0d w2=%0d b=%0d, expected served=%0d w1=%0d w2=%0d b=%0d",
               name, served, w1_o, w2_o, b_o, exp_served, e1, e2, eb);
    end
  endtask

  task automatic test_reset();
    sel = 0; nin = 1;
    @(negedge clk);
    rst0 = 1'b0;
    #1;
    vectors++;
    if ({req_o, done_o} !== 2'b00 || w1_o !== 14'sd0 || w2_o !== 14'sd0 || b_o !== 14'sd0) begin
      miscompares++;
      $display("FAIL reset_state: got req=%b done=%b w1=%0d w2=%0d b=%0d, expected all 0",
               req_o, done_o, w1_o, w2_o, b_o);
    end
    @(negedge clk);
    rst0 = 1'b1;
    vectors++;
    if (req_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_start_req: got %b, expected 0", req_o);
    end
    @(negedge clk);
    vectors++;
    if (req_o !== 1'b1) begin
      miscompares++; $display("FAIL reset_first_req: got %b, expected 1", req_o);
    end
  endtask

  task automatic test_single();
    int served;
    sel = 0; nin = 1;
    set_sample(0, 3, -2, 2'b11);
    do_reset();
    train(1, 255, 1'b0, served);
    check_final("single_sample", served, 2, -3, 2, -1);
  endtask

  task automatic test_handshake();
    int served;
    sel = 0; nin = 1;
    set_sample(0, 3, -2, 2'b11);
    do_reset();
    repeat (7) @(negedge clk);
    vectors++;
    if (req_o !== 1'b1 || w1_o !== 14'sd0 || w2_o !== 14'sd0 || b_o !== 14'sd0) begin
      miscompares++;
      $display("FAIL idle_in_req: got req=%b w1=%0d w2=%0d b=%0d, expected req=1 weights 0",
               req_o, w1_o, w2_o, b_o);
    end
    train(1, 255, 1'b1, served);
    check_final("ready_held_busy", served, 2, -3, 2, -1);
  endtask

  task automatic test_and();
    int served, y;
    sel = 0; nin = 4;
    set_sample(0, 1, 1, 2'b01);
    set_sample(1, 1, -1, 2'b11);
    set_sample(2, -1, 1, 2'b11);
    set_sample(3, -1, -1, 2'b11);
    do_reset();
    train(4, 255, 1'b0, served);
    check_final("and_gate", served, 12, 1, 1, -1);
    for (int i = 0; i < 4; i++) begin
      y = int'(b_o) + int'(w1_o) * sx1[i] + int'(w2_o) * sx2[i];
      vectors++;
      if ((y >= 0) != (st[i] == 2'b01)) begin
        miscompares++;
        $display("FAIL and_classify[%0d]: got y_in=%0d, expected target %b", i, y, st[i]);
      end
    end
  endtask

  task automatic test_n_zero();
    bit seen;
    sel = 0; nin = 0;
    do_reset();
    @(negedge clk);
    vectors++;
    if (done_o !== 1'b1) begin
      miscompares++; $display("FAIL n_zero_done: got %b, expected 1", done_o);
    end
    seen = req_o;
    repeat (5) begin
      @(negedge clk);
      seen = seen | req_o;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++; $display("FAIL n_zero_req: got request seen=%b, expected 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int served;
    bit ok;
    sel = 0; nin = 1;
    set_sample(0, 3, -2, 2'b11);
    do_reset();
    wait_ready(ok);
    x1 = 7'sd3; x2 = -7'sd2; t = 2'b11; dr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dr = 1'b0;
    wait_ready(ok);
    check_final("mid_first_update", 0, 0, -3, 2, -1);
    dr = 1'b1;
    @(posedge clk);
    #2;
    rst0 = 1'b0;
    #1;
    dr = 1'b0;
    vectors++;
    if ({req_o, done_o} !== 2'b00 || w1_o !== 14'sd0 || w2_o !== 14'sd0 || b_o !== 14'sd0) begin
      miscompares++;
      $display("FAIL mid_calc_reset: got req=%b done=%b w1=%0d w2=%0d b=%0d, expected all 0",
               req_o, done_o, w1_o, w2_o, b_o);
    end
    @(negedge clk);
    rst0 = 1'b1;
    train(1, 255, 1'b0, served);
    check_final("restart_after_reset", served, 2, -3, 2, -1);
  endtask

  task automatic test_saturation();
    int served;
    sel = 1; nin = 2;
    set_sample(0, 63, 0, 2'b01);
    set_sample(1, 0, 0, 2'b11);
    do_reset();
    train(2, 4, 1'b0, served);
    check_final("sat_positive", served, 6, 40, 0, -1);
    nin = 1;
    set_sample(0, 63, 0, 2'b11);
    do_reset();
    train(1, 4, 1'b0, served);
    check_final("sat_negative", served, 2, -40, 0, -1);
  endtask

  task automatic test_xor();
    int served;
    sel = 1; nin = 4;
    set_sample(0, 1, 1, 2'b11);
    set_sample(1, 1, -1, 2'b01);
    set_sample(2, -1, 1, 2'b01);
    set_sample(3, -1, -1, 2'b11);
    do_reset();
    train(4, 4, 1'b0, served);
    vectors++;
    if (served != 16) begin
      miscompares++; $display("FAIL xor_epoch_limit: got %0d samples, expected 16", served);
    end
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; sel = 0; dr = 1'b0;
    nin = 1; x1 = '0; x2 = '0; t = '0;
    repeat (3) @(negedge clk);
    rst1 = 1'b1;
    test_reset();
    test_single();
    test_handshake();
    test_and();
    test_n_zero();
    test_reset_mid();
    test_saturation();
    test_xor();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
